// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI bus arbiter slice.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_NEXT  = 3'd4,
    ST_GAP   = 3'd5
  } arb_state_e;

  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;

  localparam int unsigned DEF_CSN_SETUP_CYC = 2;
  localparam int unsigned DEF_CSN_GAP_CYC   = 5;
  localparam int unsigned DEF_TIMEOUT_CYC   = 1023;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_arb_timer.sv
// Loadable down-counter with zero flag; shared by setup, gap and timeout counts.
module spi_arb_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk_10,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between the TX and RX radio paths.
// Optional WAIT timeout enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CSN_SETUP_CYC = DEF_CSN_SETUP_CYC,
  parameter int unsigned CSN_GAP_CYC   = DEF_CSN_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic       clk_10,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] last,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] ack,
  output logic [1:0] rvalid,
  output logic [7:0] rdata,
  output logic [1:0] err,
  output logic       busy,
  output logic       eng_start,
  output logic [7:0] eng_wdata,
  input  logic       eng_done,
  input  logic [7:0] eng_rdata,
  output logic       csn_tx,
  output logic       csn_rx
);

  localparam int unsigned TW = $clog2(max3(CSN_SETUP_CYC, CSN_GAP_CYC, TIMEOUT_CYC) + 1);
  localparam logic [TW-1:0] SETUP_LD = TW'(CSN_SETUP_CYC - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(CSN_GAP_CYC - 1);
`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LD   = TW'(TIMEOUT_CYC - 1);
`endif

  arb_state_e  state_q, state_d;
  logic        grant_q, grant_d;
  logic        ptr_q, ptr_d;
  logic        last_q, last_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic        tmr_load;
  logic [TW-1:0] tmr_val;
  logic        tmr_zero;
  logic [1:0]  gnt_vec;

  assign gnt_vec = {grant_q == REQ_RX, grant_q == REQ_TX};

  spi_arb_timer #(
    .W(TW)
  ) u_timer (
    .clk_10     (clk_10),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_10 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= REQ_TX;
      ptr_q    <= REQ_TX;
      last_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Timer is reloaded on every state entry that needs a count; it free-runs to zero otherwise.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) begin
            grant_d = ptr_q;
          end else begin
            grant_d = req[REQ_RX] ? REQ_RX : REQ_TX;
          end
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        last_d  = last[grant_q];
        state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        tmr_load = 1'b1;
        tmr_val  = TMO_LD;
`endif
      end
      ST_WAIT: begin
        if (eng_done) begin
          rdata_d  = eng_rdata;
          rvalid_d = gnt_vec;
          if (last_q) begin
            state_d  = ST_GAP;
            ptr_d    = ~grant_q;
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end else begin
            state_d = ST_NEXT;
          end
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (tmr_zero) begin
          state_d  = ST_GAP;
          ptr_d    = ~grant_q;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
`endif
      end
      ST_NEXT: begin
        if (req[grant_q]) begin
          state_d = ST_XFER;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    csn_tx    = 1'b1;
    csn_rx    = 1'b1;
    eng_start = 1'b0;
    eng_wdata = '0;
    ack       = '0;
    err       = '0;
    case (state_q)
      ST_SETUP, ST_WAIT, ST_NEXT: begin
        busy   = 1'b1;
        csn_tx = (grant_q != REQ_TX);
        csn_rx = (grant_q != REQ_RX);
      end
      ST_XFER: begin
        busy      = 1'b1;
        csn_tx    = (grant_q != REQ_TX);
        csn_rx    = (grant_q != REQ_RX);
        eng_start = 1'b1;
        eng_wdata = (grant_q == REQ_RX) ? wdata1 : wdata0;
        ack       = gnt_vec;
      end
      default: ;
    endcase
`ifdef SPI_ARB_TIMEOUT_EN
    if (state_q == ST_WAIT && !eng_done && tmr_zero) begin
      err = gnt_vec;
    end
`endif
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter (timeout scenario needs SPI_ARB_TIMEOUT_EN).
module tb_spi_bus_arbiter;

  logic       clk_10;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] last;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] ack;
  logic [1:0] rvalid;
  logic [7:0] rdata;
  logic [1:0] err;
  logic       busy;
  logic       eng_start;
  logic [7:0] eng_wdata;
  logic       eng_done;
  logic [7:0] eng_rdata;
  logic       csn_tx;
  logic       csn_rx;

  int checks = 0;
  int errors = 0;
  int ack1_cnt = 0;
  int both_low_cnt = 0;

  spi_bus_arbiter #(
    .CSN_SETUP_CYC(2),
    .CSN_GAP_CYC  (5),
    .TIMEOUT_CYC  (8)
  ) dut (
    .clk_10    (clk_10),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .err       (err),
    .busy      (busy),
    .eng_start (eng_start),
    .eng_wdata (eng_wdata),
    .eng_done  (eng_done),
    .eng_rdata (eng_rdata),
    .csn_tx    (csn_tx),
    .csn_rx    (csn_rx)
  );

  initial clk_10 = 1'b0;
  always #5 clk_10 = ~clk_10;

  always @(negedge clk_10) begin
    if (ack[1] === 1'b1) ack1_cnt++;
    if (csn_tx === 1'b0 && csn_rx === 1'b0) both_low_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_10);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_10);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      mid();
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      mid();
      if (eng_start === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Called at the negedge of the XFER cycle; returns at the negedge of the rvalid cycle.
  task automatic engine_reply(input logic [7:0] d, input int lat, input logic [1:0] drop);
    for (int i = 1; i <= lat; i++) begin
      step();
      if (i == 1) req = req & ~drop;
      if (i == lat) begin
        eng_done  = 1'b1;
        eng_rdata = d;
      end
      mid();
    end
    step();
    eng_done  = 1'b0;
    eng_rdata = '0;
    mid();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0; last = '0; wdata0 = '0; wdata1 = '0;
    eng_done = 1'b0; eng_rdata = '0;
    repeat (2) @(posedge clk_10);
    mid();
    checks++;
    if ({csn_tx, csn_rx, busy, eng_start, ack, rvalid, err} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got csn=%b%b busy=%b start=%b ack=%b rvalid=%b err=%b, expected csn=11 rest 0",
               csn_tx, csn_rx, busy, eng_start, ack, rvalid, err);
    end
    checks++;
    if (rdata !== 8'h00 || eng_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h eng_wdata=%h, expected 00 00", rdata, eng_wdata);
    end
    step();
    rst_n = 1'b1;
    mid();
    idle(2);
  endtask

  task automatic test_tie();
    int n;
    int k;
    step(); req = 2'b11; last = 2'b11; wdata0 = 8'hA1; wdata1 = 8'hB2; mid();
    step(); mid();
    checks++;
    if (csn_tx !== 1'b0 || csn_rx !== 1'b1) begin
      errors++;
      $display("FAIL tie_first_grant: got csn_tx=%b csn_rx=%b, expected 0 1", csn_tx, csn_rx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'hA1 || ack !== 2'b01) begin
      errors++;
      $display("FAIL tie_tx_xfer: got n=%0d wdata=%h ack=%b, expected 2 a1 01", n, eng_wdata, ack);
    end
    engine_reply(8'h11, 2, 2'b01);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'h11 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL tie_tx_done: got rvalid=%b rdata=%h csn_tx=%b, expected 01 11 1", rvalid, rdata, csn_tx);
    end
    k = -1;
    for (int i = 1; i <= 20; i++) begin
      step(); mid();
      if (csn_rx === 1'b0) begin
        k = i;
        break;
      end
    end
    checks++;
    if (k !== 6 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL tie_rx_gap: got csn_rx low after %0d cycles csn_tx=%b, expected 6 1", k, csn_tx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'hB2 || ack !== 2'b10) begin
      errors++;
      $display("FAIL tie_rx_xfer: got n=%0d wdata=%h ack=%b, expected 2 b2 10", n, eng_wdata, ack);
    end
    engine_reply(8'h22, 1, 2'b10);
    checks++;
    if (rvalid !== 2'b10 || rdata !== 8'h22) begin
      errors++;
      $display("FAIL tie_rx_done: got rvalid=%b rdata=%h, expected 10 22", rvalid, rdata);
    end
    idle(5);
  endtask

  task automatic test_single();
    int n;
    int bad;
    step(); req = 2'b01; last = 2'b01; wdata0 = 8'hFF; mid();
    checks++;
    if (csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_c0: got csn_tx=%b, expected 1", csn_tx);
    end
    step(); mid();
    checks++;
    if (csn_tx !== 1'b0 || csn_rx !== 1'b1 || busy !== 1'b1 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: got csn_tx=%b csn_rx=%b busy=%b start=%b, expected 0 1 1 0",
               csn_tx, csn_rx, busy, eng_start);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'hFF || ack !== 2'b01) begin
      errors++;
      $display("FAIL single_xfer: got n=%0d wdata=%h ack=%b, expected 2 ff 01", n, eng_wdata, ack);
    end
    engine_reply(8'h0E, 2, 2'b01);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'h0E || csn_tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got rvalid=%b rdata=%h csn_tx=%b busy=%b, expected 01 0e 1 0",
               rvalid, rdata, csn_tx, busy);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step(); mid();
      if (csn_tx !== 1'b1 || csn_rx !== 1'b1 || busy !== 1'b0 || rvalid !== 2'b00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL single_gap: got %0d bad gap cycles, expected 0", bad);
    end
    idle(1);
  endtask

  task automatic test_tie_rx();
    int n;
    step(); req = 2'b11; last = 2'b11; wdata0 = 8'hC3; wdata1 = 8'hD4; mid();
    step(); mid();
    checks++;
    if (csn_rx !== 1'b0 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL tie2_grant: got csn_tx=%b csn_rx=%b, expected 1 0", csn_tx, csn_rx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'hD4 || ack !== 2'b10) begin
      errors++;
      $display("FAIL tie2_rx_xfer: got n=%0d wdata=%h ack=%b, expected 2 d4 10", n, eng_wdata, ack);
    end
    engine_reply(8'h55, 2, 2'b10);
    checks++;
    if (rvalid !== 2'b10 || rdata !== 8'h55) begin
      errors++;
      $display("FAIL tie2_rx_done: got rvalid=%b rdata=%h, expected 10 55", rvalid, rdata);
    end
    wait_start(20, n);
    checks++;
    if (n !== 8 || eng_wdata !== 8'hC3 || ack !== 2'b01) begin
      errors++;
      $display("FAIL tie2_tx_xfer: got n=%0d wdata=%h ack=%b, expected 8 c3 01", n, eng_wdata, ack);
    end
    engine_reply(8'h66, 1, 2'b01);
    idle(5);
  endtask

  task automatic test_lock();
    int n;
    int a0;
    a0 = ack1_cnt;
    step(); req = 2'b01; last = 2'b00; wdata0 = 8'h20; mid();
    step(); req = 2'b11; wdata1 = 8'hEE; last = 2'b10; mid();
    checks++;
    if (csn_tx !== 1'b0 || csn_rx !== 1'b1) begin
      errors++;
      $display("FAIL lock_grant: got csn_tx=%b csn_rx=%b, expected 0 1", csn_tx, csn_rx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'h20 || ack !== 2'b01) begin
      errors++;
      $display("FAIL lock_b0: got n=%0d wdata=%h ack=%b, expected 2 20 01", n, eng_wdata, ack);
    end
    step(); wdata0 = 8'h3F; mid();
    engine_reply(8'hA0, 1, 2'b00);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'hA0 || csn_tx !== 1'b0) begin
      errors++;
      $display("FAIL lock_next0: got rvalid=%b rdata=%h csn_tx=%b, expected 01 a0 0", rvalid, rdata, csn_tx);
    end
    step(); mid();
    checks++;
    if (eng_start !== 1'b1 || eng_wdata !== 8'h3F || ack !== 2'b01) begin
      errors++;
      $display("FAIL lock_b1: got start=%b wdata=%h ack=%b, expected 1 3f 01", eng_start, eng_wdata, ack);
    end
    step(); wdata0 = 8'h01; last = 2'b11; mid();
    engine_reply(8'hA1, 1, 2'b00);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'hA1 || csn_tx !== 1'b0) begin
      errors++;
      $display("FAIL lock_next1: got rvalid=%b rdata=%h csn_tx=%b, expected 01 a1 0", rvalid, rdata, csn_tx);
    end
    step(); mid();
    checks++;
    if (eng_start !== 1'b1 || eng_wdata !== 8'h01 || ack !== 2'b01) begin
      errors++;
      $display("FAIL lock_b2: got start=%b wdata=%h ack=%b, expected 1 01 01", eng_start, eng_wdata, ack);
    end
    engine_reply(8'hA2, 2, 2'b01);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'hA2 || csn_tx !== 1'b1 || csn_rx !== 1'b1 || ack1_cnt !== a0) begin
      errors++;
      $display("FAIL lock_end: got rvalid=%b rdata=%h csn=%b%b rx_acks=%0d, expected 01 a2 11 0",
               rvalid, rdata, csn_tx, csn_rx, ack1_cnt - a0);
    end
    wait_start(20, n);
    checks++;
    if (n !== 8 || eng_wdata !== 8'hEE || ack !== 2'b10) begin
      errors++;
      $display("FAIL lock_rx_after: got n=%0d wdata=%h ack=%b, expected 8 ee 10", n, eng_wdata, ack);
    end
    engine_reply(8'h77, 1, 2'b10);
    idle(5);
  endtask

  task automatic test_stall();
    int n;
    int bad;
    step(); req = 2'b01; last = 2'b00; wdata0 = 8'h5A; mid();
    wait_start(10, n);
    checks++;
    if (n !== 3 || eng_wdata !== 8'h5A || ack !== 2'b01) begin
      errors++;
      $display("FAIL stall_b0: got n=%0d wdata=%h ack=%b, expected 3 5a 01", n, eng_wdata, ack);
    end
    engine_reply(8'h11, 1, 2'b01);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'h11 || csn_tx !== 1'b0) begin
      errors++;
      $display("FAIL stall_next: got rvalid=%b rdata=%h csn_tx=%b, expected 01 11 0", rvalid, rdata, csn_tx);
    end
    step(); req = 2'b10; wdata1 = 8'h99; last = 2'b10; mid();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(); mid();
      if (csn_tx !== 1'b0 || csn_rx !== 1'b1 || eng_start !== 1'b0 || ack !== 2'b00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d bad stall cycles, expected 0", bad);
    end
    step(); req = 2'b11; wdata0 = 8'h6B; last = 2'b11; mid();
    step(); mid();
    checks++;
    if (eng_start !== 1'b1 || eng_wdata !== 8'h6B || ack !== 2'b01) begin
      errors++;
      $display("FAIL stall_resume: got start=%b wdata=%h ack=%b, expected 1 6b 01", eng_start, eng_wdata, ack);
    end
    engine_reply(8'h12, 1, 2'b01);
    checks++;
    if (rvalid !== 2'b01 || rdata !== 8'h12 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got rvalid=%b rdata=%h csn_tx=%b, expected 01 12 1", rvalid, rdata, csn_tx);
    end
    wait_start(20, n);
    checks++;
    if (n !== 8 || eng_wdata !== 8'h99 || ack !== 2'b10) begin
      errors++;
      $display("FAIL stall_rx: got n=%0d wdata=%h ack=%b, expected 8 99 10", n, eng_wdata, ack);
    end
    engine_reply(8'h13, 1, 2'b10);
    idle(5);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int k;
    int bad;
    logic [1:0] e;
    step(); req = 2'b01; last = 2'b01; wdata0 = 8'hC0; mid();
    wait_start(10, n);
    checks++;
    if (n !== 3 || ack !== 2'b01) begin
      errors++;
      $display("FAIL tmo_xfer: got n=%0d ack=%b, expected 3 01", n, ack);
    end
    k = -1; bad = 0; e = '0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 1) req = 2'b00;
      mid();
      if (rvalid !== 2'b00) bad++;
      if (err !== 2'b00) begin
        k = i;
        e = err;
        break;
      end
    end
    checks++;
    if (k !== 8 || e !== 2'b01 || bad !== 0) begin
      errors++;
      $display("FAIL tmo_err: got err=%b after %0d cycles rvalids=%0d, expected 01 8 0", e, k, bad);
    end
    step(); mid();
    checks++;
    if (csn_tx !== 1'b1 || err !== 2'b00 || rvalid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_gap: got csn_tx=%b err=%b rvalid=%b busy=%b, expected 1 00 00 0",
               csn_tx, err, rvalid, busy);
    end
    idle(4);
    step(); req = 2'b11; last = 2'b11; wdata1 = 8'hF0; mid();
    step(); mid();
    checks++;
    if (csn_rx !== 1'b0 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL tmo_next_rx: got csn_tx=%b csn_rx=%b, expected 1 0", csn_tx, csn_rx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || ack !== 2'b10 || eng_wdata !== 8'hF0) begin
      errors++;
      $display("FAIL tmo_rx_xfer: got n=%0d ack=%b wdata=%h, expected 2 10 f0", n, ack, eng_wdata);
    end
    engine_reply(8'h01, 1, 2'b11);
    idle(5);
  endtask
`endif

  task automatic test_reset_mid_wait();
    int n;
    step(); req = 2'b01; last = 2'b01; wdata0 = 8'hE7; mid();
    wait_start(10, n);
    step(); req = 2'b00; mid();
    checks++;
    if (csn_tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got csn_tx=%b busy=%b, expected 0 1", csn_tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({csn_tx, csn_rx, busy, eng_start, ack, rvalid, err} !== 10'b11_0000_0000) begin
      errors++;
      $display("FAIL rst_async: got csn=%b%b busy=%b start=%b ack=%b rvalid=%b err=%b, expected csn=11 rest 0",
               csn_tx, csn_rx, busy, eng_start, ack, rvalid, err);
    end
    step(); mid();
    step(); rst_n = 1'b1; mid();
    checks++;
    if (rvalid !== 2'b00 || ack !== 2'b00 || csn_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got rvalid=%b ack=%b csn_tx=%b, expected 00 00 1", rvalid, ack, csn_tx);
    end
    step(); req = 2'b11; last = 2'b11; wdata0 = 8'h3C; wdata1 = 8'h4D; mid();
    step(); mid();
    checks++;
    if (csn_tx !== 1'b0 || csn_rx !== 1'b1) begin
      errors++;
      $display("FAIL rst_tie: got csn_tx=%b csn_rx=%b, expected 0 1", csn_tx, csn_rx);
    end
    wait_start(10, n);
    checks++;
    if (n !== 2 || eng_wdata !== 8'h3C || ack !== 2'b01) begin
      errors++;
      $display("FAIL rst_tie_xfer: got n=%0d wdata=%h ack=%b, expected 2 3c 01", n, eng_wdata, ack);
    end
    engine_reply(8'h5E, 1, 2'b11);
    idle(6);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_tie_rx();
    test_lock();
    test_stall();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    checks++;
    if (both_low_cnt !== 0) begin
      errors++;
      $display("FAIL csn_exclusive: got %0d cycles with both CSN low, expected 0", both_low_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
